// File: rtl/decode_stage_pkg.sv
// mips_pkg: instruction encodings shared by the decode stage and its register
// file. The opcode enum is used only for compares against instr[31:26].
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  localparam logic [5:0]  FUNCT_JR = 6'h08;
  localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: every non-clock signal of the decode stage.
//   fetch side : if_pc_sum, if_instr in; pc_hold, pc_sel, jump_address out
//   hazard side: ex_reg_write, ex_mem_read, ex_dest, mem_reg_write, mem_dest in
//   write-back : wb_reg_write, wb_dest, wb_data in
//   execute    : id_* decoded fields/operands and id_bubble out
// master = the decode stage, slave = its environment.
interface decode_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic [DATA_W-1:0] if_pc_sum;
  logic [31:0]       if_instr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_dest;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_dest;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              pc_hold;
  logic              pc_sel;
  logic [DATA_W-1:0] jump_address;
  logic [DATA_W-1:0] id_pc_sum;
  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [4:0]        id_shamt;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm_ext;
  logic              id_bubble;

  modport master (
    input  if_pc_sum, if_instr, ex_reg_write, ex_mem_read, ex_dest,
           mem_reg_write, mem_dest, wb_reg_write, wb_dest, wb_data,
    output pc_hold, pc_sel, jump_address, id_pc_sum, id_opcode, id_funct,
           id_rs, id_rt, id_rd, id_shamt, id_rdata1, id_rdata2, id_imm_ext,
           id_bubble
  );

  modport slave (
    output if_pc_sum, if_instr, ex_reg_write, ex_mem_read, ex_dest,
           mem_reg_write, mem_dest, wb_reg_write, wb_dest, wb_data,
    input  pc_hold, pc_sel, jump_address, id_pc_sum, id_opcode, id_funct,
           id_rs, id_rt, id_rd, id_shamt, id_rdata1, id_rdata2, id_imm_ext,
           id_bubble
  );
endinterface

// File: rtl/decode_stage_reg_file.sv
// reg_file: 2-read/1-write register file, async active-high reset clears all.
//   raddr1/raddr2 -> rdata1/rdata2 : combinational reads
//   we/waddr/wdata                 : write on posedge clk, $0 never written
// A read of the address being written this cycle returns wdata (bypass);
// $0 always reads zero.
module reg_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);
  localparam int unsigned NREGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == '0)                    rdata1 = '0;
    else if (we && raddr1 == waddr)      rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == '0)                    rdata2 = '0;
    else if (we && raddr2 == waddr)      rdata2 = wdata;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS instruction-decode stage.
//   clk, rst : clock, async active-high reset
//   bus      : decode_stage_if.master (fetch, hazard, write-back, execute sides)
// Holds the IF/ID register and register file, extends the immediate, detects
// load-use and branch-operand hazards, and resolves J/JAL/JR/BEQ/BNE in ID.
// The jump target concatenation assumes DATA_W = 32.
module decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic            clk,
  input logic            rst,
  decode_stage_if.master bus
);
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] pc_sum_q;
  logic              valid_q;

  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rdata1, rdata2, imm_ext, imm_sext, target;
  logic              is_jr, is_jump, is_branch, rt_used;
  logic              load_use, ex_dep, mem_dep, stall, taken;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];

  assign is_jr     = (opcode == OP_RTYPE) && (funct == FUNCT_JR);
  assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  // Instructions that actually consume rt as a source operand.
  assign rt_used   = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_branch;

  assign imm_sext = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
  assign imm_ext  = (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
                    ? {{(DATA_W-16){1'b0}}, instr_q[15:0]} : imm_sext;

  reg_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (bus.wb_reg_write),
    .waddr  (bus.wb_dest),
    .wdata  (bus.wb_data)
  );

  // Branch/JR compare in ID, so producers still in EX or MEM cannot be
  // forwarded here yet; only BEQ/BNE read rt, JR reads rs alone.
  assign load_use = bus.ex_mem_read && bus.ex_dest != '0 &&
                    (bus.ex_dest == rs || (bus.ex_dest == rt && rt_used));
  assign ex_dep   = bus.ex_reg_write && bus.ex_dest != '0 &&
                    (bus.ex_dest == rs || (bus.ex_dest == rt && is_branch));
  assign mem_dep  = bus.mem_reg_write && bus.mem_dest != '0 &&
                    (bus.mem_dest == rs || (bus.mem_dest == rt && is_branch));
  assign stall    = valid_q && (load_use || ((is_branch || is_jr) && (ex_dep || mem_dep)));

  always_comb begin
    taken  = 1'b0;
    target = '0;
    if (valid_q && !stall) begin
      if (is_jump) begin
        taken  = 1'b1;
        target = {pc_sum_q[DATA_W-1:DATA_W-4], instr_q[25:0], 2'b00};
      end else if (is_jr) begin
        taken  = 1'b1;
        target = rdata1;
      end else if (is_branch && ((rdata1 == rdata2) == (opcode == OP_BEQ))) begin
        taken  = 1'b1;
        target = pc_sum_q + {imm_sext[DATA_W-3:0], 2'b00};
      end
    end
  end

  // Stall beats flush beats load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= NOP;
      pc_sum_q <= '0;
      valid_q  <= 1'b0;
    end else if (!stall) begin
      pc_sum_q <= bus.if_pc_sum;
      if (taken) begin
        instr_q <= NOP;
        valid_q <= 1'b0;
      end else begin
        instr_q <= bus.if_instr;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.pc_hold      = stall;
  assign bus.pc_sel       = !taken;
  assign bus.jump_address = target;
  assign bus.id_pc_sum    = pc_sum_q;
  assign bus.id_opcode    = opcode;
  assign bus.id_funct     = funct;
  assign bus.id_rs        = rs;
  assign bus.id_rt        = rt;
  assign bus.id_rd        = rd;
  assign bus.id_shamt     = instr_q[10:6];
  assign bus.id_rdata1    = rdata1;
  assign bus.id_rdata2    = rdata2;
  assign bus.id_imm_ext   = imm_ext;
  assign bus.id_bubble    = !valid_q || stall;
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc, instr;
    logic        ex_rw, ex_mr;
    logic [4:0]  ex_dest;
    logic        mem_rw;
    logic [4:0]  mem_dest;
    logic        wb_rw;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        hold, sel;
    logic [31:0] jaddr, r1, r2, imm;
    logic        bubble;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(string n, logic [31:0] pc, logic [31:0] instr,
                              logic ex_rw, logic ex_mr, logic [4:0] ex_dest,
                              logic mem_rw, logic [4:0] mem_dest,
                              logic wb_rw, logic [4:0] wb_dest, logic [31:0] wb_data,
                              logic hold, logic sel, logic [31:0] jaddr,
                              logic [31:0] r1, logic [31:0] r2, logic [31:0] imm,
                              logic bubble);
    vec_t v;
    v.name = n; v.pc = pc; v.instr = instr;
    v.ex_rw = ex_rw; v.ex_mr = ex_mr; v.ex_dest = ex_dest;
    v.mem_rw = mem_rw; v.mem_dest = mem_dest;
    v.wb_rw = wb_rw; v.wb_dest = wb_dest; v.wb_data = wb_data;
    v.hold = hold; v.sel = sel; v.jaddr = jaddr;
    v.r1 = r1; v.r2 = r2; v.imm = imm; v.bubble = bubble;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_side();
    bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_dest = '0;
    bus.mem_reg_write = 1'b0; bus.mem_dest = '0;
    bus.wb_reg_write = 1'b0; bus.wb_dest = '0; bus.wb_data = '0;
  endtask

  task automatic wb_write(input logic [4:0] d, input logic [31:0] data);
    bus.wb_reg_write = 1'b1; bus.wb_dest = d; bus.wb_data = data;
    @(posedge clk); #1;
    bus.wb_reg_write = 1'b0;
  endtask

  task automatic load_id(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_pc_sum = 32'h0; bus.if_instr = 32'h0;
    @(posedge clk); #1;
    bus.if_pc_sum = pc; bus.if_instr = instr;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, e;
    logic [31:0] ins;
    clear_side();
    bus.if_pc_sum = '0; bus.if_instr = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_hold", {31'b0, bus.pc_hold}, 32'd0);
    check("rst_sel", {31'b0, bus.pc_sel}, 32'd1);
    check("rst_jaddr", bus.jump_address, 32'h0);
    check("rst_bubble", {31'b0, bus.id_bubble}, 32'd1);
    check("rst_pc_sum", bus.id_pc_sum, 32'h0);
    check("rst_opcode", {26'b0, bus.id_opcode}, 32'h0);
    #9 rst = 1'b0;

    @(posedge clk); #1;
    wb_write(5'd1, 32'h11); wb_write(5'd2, 32'h11); wb_write(5'd4, 32'h44);
    wb_write(5'd6, 32'h66); wb_write(5'd7, 32'h22); wb_write(5'd8, 32'h88);
    wb_write(5'd31, 32'h0040_0100);

    //                name                 pc            instr         exrw exmr exd memrw memd wbrw wbd wbdata        hold sel jaddr         r1            r2            imm           bub
    vecs.push_back(mk("wb_bypass",         32'h00400000, 32'h00A61820, 0, 0, 5'd0,  0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 1, 32'h0,        32'hDEADBEEF, 32'h66,       32'h00001820, 0));
    vecs.push_back(mk("wb_disabled",       32'h00400000, 32'h00A61820, 0, 0, 5'd0,  0, 5'd0, 0, 5'd5, 32'hDEADBEEF, 0, 1, 32'h0,        32'h0,        32'h66,       32'h00001820, 0));
    vecs.push_back(mk("wb_bypass_rt",      32'h00400000, 32'h00A61820, 0, 0, 5'd0,  0, 5'd0, 1, 5'd6, 32'h0000600D, 0, 1, 32'h0,        32'h0,        32'h600D,     32'h00001820, 0));
    vecs.push_back(mk("wb_r0",             32'h00400000, 32'h00061820, 0, 0, 5'd0,  0, 5'd0, 1, 5'd0, 32'h12345678, 0, 1, 32'h0,        32'h0,        32'h66,       32'h00001820, 0));
    vecs.push_back(mk("load_use_rs",       32'h00400000, 32'h01014820, 1, 1, 5'd8,  0, 5'd0, 0, 5'd0, 32'h0,        1, 1, 32'h0,        32'h88,       32'h11,       32'h00004820, 1));
    vecs.push_back(mk("alu_ex_nostall",    32'h00400000, 32'h01014820, 1, 0, 5'd8,  0, 5'd0, 0, 5'd0, 32'h0,        0, 1, 32'h0,        32'h88,       32'h11,       32'h00004820, 0));
    vecs.push_back(mk("load_dest0",        32'h00400000, 32'h00061820, 1, 1, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 1, 32'h0,        32'h0,        32'h66,       32'h00001820, 0));
    vecs.push_back(mk("lw_rt_nostall",     32'h00400000, 32'h8C280004, 1, 1, 5'd8,  0, 5'd0, 0, 5'd0, 32'h0,        0, 1, 32'h0,        32'h11,       32'h88,       32'h00000004, 0));
    vecs.push_back(mk("sw_rt_stall",       32'h00400000, 32'hAC28FFF8, 1, 1, 5'd8,  0, 5'd0, 0, 5'd0, 32'h0,        1, 1, 32'h0,        32'h11,       32'h88,       32'hFFFFFFF8, 1));
    vecs.push_back(mk("ori_zext",          32'h00400000, 32'h34228001, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 1, 32'h0,        32'h11,       32'h11,       32'h00008001, 0));
    vecs.push_back(mk("andi_zext",         32'h00400000, 32'h3000FFFF, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 1, 32'h0,        32'h0,        32'h0,        32'h0000FFFF, 0));
    vecs.push_back(mk("xori_zext",         32'h00400000, 32'h3800FFFF, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 1, 32'h0,        32'h0,        32'h0,        32'h0000FFFF, 0));
    vecs.push_back(mk("addi_sext",         32'h00400000, 32'h2000FFFF, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 1, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 0));
    vecs.push_back(mk("beq_taken",         32'h00400008, 32'h10220003, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h00400014, 32'h11,       32'h11,       32'h00000003, 0));
    vecs.push_back(mk("beq_not_taken",     32'h00400008, 32'h10270003, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 1, 32'h0,        32'h11,       32'h22,       32'h00000003, 0));
    vecs.push_back(mk("bne_taken",         32'h00400008, 32'h14270003, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h00400014, 32'h11,       32'h22,       32'h00000003, 0));
    vecs.push_back(mk("j",                 32'h00400010, 32'h08100004, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h00400010, 32'h0,        32'h0,        32'h00000004, 0));
    vecs.push_back(mk("jal",               32'hA0000000, 32'h0C000001, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'hA0000004, 32'h0,        32'h0,        32'h00000001, 0));
    vecs.push_back(mk("jr",                32'h00400000, 32'h03E00008, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h00400100, 32'h00400100, 32'h0,        32'h00000008, 0));
    vecs.push_back(mk("jr_ex_stall",       32'h00400000, 32'h03E00008, 1, 0, 5'd31, 0, 5'd0, 0, 5'd0, 32'h0,        1, 1, 32'h0,        32'h00400100, 32'h0,        32'h00000008, 1));
    vecs.push_back(mk("beq_mem_rt_stall",  32'h00400008, 32'h10220003, 0, 0, 5'd0,  1, 5'd2, 0, 5'd0, 32'h0,        1, 1, 32'h0,        32'h11,       32'h11,       32'h00000003, 1));
    vecs.push_back(mk("beq_ex_rs_stall",   32'h00400008, 32'h10220003, 1, 0, 5'd1,  0, 5'd0, 0, 5'd0, 32'h0,        1, 1, 32'h0,        32'h11,       32'h11,       32'h00000003, 1));
    vecs.push_back(mk("beq_ex_unrelated",  32'h00400008, 32'h10220003, 1, 0, 5'd5,  1, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'h00400014, 32'h11,       32'h11,       32'h00000003, 0));
    vecs.push_back(mk("bne_wrap",          32'h00000000, 32'h1480FFFF, 0, 0, 5'd0,  0, 5'd0, 0, 5'd0, 32'h0,        0, 0, 32'hFFFFFFFC, 32'h44,       32'h0,        32'hFFFFFFFF, 0));

    foreach (vecs[i]) begin
      v = vecs[i];
      clear_side();
      load_id(v.pc, v.instr);
      bus.ex_reg_write = v.ex_rw; bus.ex_mem_read = v.ex_mr; bus.ex_dest = v.ex_dest;
      bus.mem_reg_write = v.mem_rw; bus.mem_dest = v.mem_dest;
      bus.wb_reg_write = v.wb_rw; bus.wb_dest = v.wb_dest; bus.wb_data = v.wb_data;
      sb.push_back(v);
      #1;
      e = sb.pop_front();
      ins = e.instr;
      check({e.name, ".hold"},   {31'b0, bus.pc_hold},   {31'b0, e.hold});
      check({e.name, ".sel"},    {31'b0, bus.pc_sel},    {31'b0, e.sel});
      check({e.name, ".jaddr"},  bus.jump_address,       e.jaddr);
      check({e.name, ".r1"},     bus.id_rdata1,          e.r1);
      check({e.name, ".r2"},     bus.id_rdata2,          e.r2);
      check({e.name, ".imm"},    bus.id_imm_ext,         e.imm);
      check({e.name, ".bubble"}, {31'b0, bus.id_bubble}, {31'b0, e.bubble});
      check({e.name, ".pc_sum"}, bus.id_pc_sum,          e.pc);
      check({e.name, ".opcode"}, {26'b0, bus.id_opcode}, {26'b0, ins[31:26]});
      check({e.name, ".rs"},     {27'b0, bus.id_rs},     {27'b0, ins[25:21]});
      check({e.name, ".rt"},     {27'b0, bus.id_rt},     {27'b0, ins[20:16]});
      check({e.name, ".rd"},     {27'b0, bus.id_rd},     {27'b0, ins[15:11]});
      check({e.name, ".shamt"},  {27'b0, bus.id_shamt},  {27'b0, ins[10:6]});
      check({e.name, ".funct"},  {26'b0, bus.id_funct},  {26'b0, ins[5:0]});
    end
    clear_side();

    // Load-use stall holds IF/ID; a WB write to the stalled source bypasses.
    load_id(32'h00000200, 32'h01014820);
    bus.if_pc_sum = 32'h00000204; bus.if_instr = 32'h00A61820;
    bus.ex_mem_read = 1'b1; bus.ex_dest = 5'd8;
    bus.wb_reg_write = 1'b1; bus.wb_dest = 5'd8; bus.wb_data = 32'hCAFEF00D;
    #1;
    check("lu.hold", {31'b0, bus.pc_hold}, 32'd1);
    check("lu.wb_bypass", bus.id_rdata1, 32'hCAFEF00D);
    @(posedge clk); #1;
    bus.wb_reg_write = 1'b0;
    #1;
    check("lu.held_pc", bus.id_pc_sum, 32'h00000200);
    check("lu.held_rd", {27'b0, bus.id_rd}, 32'd9);
    check("lu.committed", bus.id_rdata1, 32'hCAFEF00D);
    check("lu.bubble", {31'b0, bus.id_bubble}, 32'd1);
    bus.ex_mem_read = 1'b0;
    #1;
    check("lu.release_bubble", {31'b0, bus.id_bubble}, 32'd0);
    check("lu.release_hold", {31'b0, bus.pc_hold}, 32'd0);
    @(posedge clk); #1;
    check("lu.next_pc", bus.id_pc_sum, 32'h00000204);

    // Taken branch flushes the following slot.
    load_id(32'h00400008, 32'h10220003);
    check("fl.sel", {31'b0, bus.pc_sel}, 32'd0);
    check("fl.jaddr", bus.jump_address, 32'h00400014);
    bus.if_pc_sum = 32'h0040000C; bus.if_instr = 32'h00261820;
    @(posedge clk); #1;
    check("fl.opcode", {26'b0, bus.id_opcode}, 32'd0);
    check("fl.funct", {26'b0, bus.id_funct}, 32'd0);
    check("fl.rs", {27'b0, bus.id_rs}, 32'd0);
    check("fl.bubble", {31'b0, bus.id_bubble}, 32'd1);
    check("fl.sel_after", {31'b0, bus.pc_sel}, 32'd1);
    @(posedge clk); #1;
    check("fl.reload_bubble", {31'b0, bus.id_bubble}, 32'd0);
    check("fl.reload_pc", bus.id_pc_sum, 32'h0040000C);

    // BNE stalled on a MEM producer: no redirect while stalled, then wraps.
    load_id(32'h00000000, 32'h1480FFFF);
    bus.if_pc_sum = 32'h00000004; bus.if_instr = 32'h00061820;
    bus.mem_reg_write = 1'b1; bus.mem_dest = 5'd4;
    #1;
    check("bs.hold", {31'b0, bus.pc_hold}, 32'd1);
    check("bs.sel", {31'b0, bus.pc_sel}, 32'd1);
    check("bs.jaddr", bus.jump_address, 32'h0);
    check("bs.bubble", {31'b0, bus.id_bubble}, 32'd1);
    @(posedge clk); #1;
    bus.mem_reg_write = 1'b0;
    #1;
    check("bs.held_pc", bus.id_pc_sum, 32'h00000000);
    check("bs.sel_after", {31'b0, bus.pc_sel}, 32'd0);
    check("bs.jaddr_after", bus.jump_address, 32'hFFFFFFFC);
    check("bs.bubble_after", {31'b0, bus.id_bubble}, 32'd0);

    // Reset asserted mid-stall, then the first instruction after release.
    load_id(32'h00000300, 32'h00261820);
    check("pre_rst.r1", bus.id_rdata1, 32'h11);
    bus.if_instr = 32'h01014820;
    @(posedge clk); #1;
    bus.ex_mem_read = 1'b1; bus.ex_dest = 5'd8;
    #1;
    check("pre_rst.hold", {31'b0, bus.pc_hold}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr.hold", {31'b0, bus.pc_hold}, 32'd0);
    check("mr.sel", {31'b0, bus.pc_sel}, 32'd1);
    check("mr.jaddr", bus.jump_address, 32'h0);
    check("mr.bubble", {31'b0, bus.id_bubble}, 32'd1);
    check("mr.pc_sum", bus.id_pc_sum, 32'h0);
    check("mr.rs", {27'b0, bus.id_rs}, 32'd0);
    clear_side();
    bus.if_pc_sum = 32'h00000100; bus.if_instr = 32'h00261820;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst.bubble", {31'b0, bus.id_bubble}, 32'd1);
    @(posedge clk); #1;
    check("post_rst.bubble_clear", {31'b0, bus.id_bubble}, 32'd0);
    check("post_rst.pc_sum", bus.id_pc_sum, 32'h00000100);
    check("post_rst.r1_cleared", bus.id_rdata1, 32'h0);
    check("post_rst.r2_cleared", bus.id_rdata2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
